// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store engine: funct3 codes,
// FSM state type and the byte-lane helpers used on the request path.
package mem_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NBYTES = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double.
  function automatic logic [7:0] byte_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [15:0] m;
    unique case (size)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    unique case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        wen;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        resp_valid;
  logic [63:0] rdata;

  modport master (
    output req_valid, addr, wen, wdata, wstrb,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wstrb,
    output req_ready, resp_valid, rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load extraction: shifts the addressed bytes of the aligned
// doubleword down to bit 0 and sign/zero-extends according to funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);

  logic [63:0] w_raw;

  always_comb begin
    w_raw  = i_rdata >> {i_off, 3'b000};
    o_data = w_raw;
    unique case (i_funct3)
      F3_LB:   o_data = {{56{w_raw[7]}},  w_raw[7:0]};
      F3_LH:   o_data = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_LW:   o_data = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_LBU:  o_data = {56'd0, w_raw[7:0]};
      F3_LHU:  o_data = {48'd0, w_raw[15:0]};
      F3_LWU:  o_data = {32'd0, w_raw[31:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one bus transaction per regM memory op,
// stalling the pipeline until the response/ack, then presenting load data.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               regM_i_valid,
  input  logic               regM_i_mem_ren,
  input  logic               regM_i_mem_wen,
  input  logic [2:0]         regM_i_funct3,
  input  logic [63:0]        regM_i_alu_result,
  input  logic [63:0]        regM_i_rs2_data,
  mem_access_unit_if.master  dmem,
  output logic [63:0]        memory_o_memdata,
  output logic               memory_o_stall,
  output logic               memory_o_misaligned
);

  mem_state_t  r_state;
  mem_state_t  w_next_state;

  logic [2:0]  r_funct3;
  logic [2:0]  r_off;
  logic [63:0] r_req_addr;
  logic        r_req_wen;
  logic [63:0] r_req_wdata;
  logic [7:0]  r_req_wstrb;
  logic [63:0] r_memdata;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_latch;
  logic        w_capture;
  logic [63:0] w_load_data;
  logic [2:0]  w_in_off;

  assign w_in_off     = regM_i_alu_result[2:0];
  assign w_mem_op     = regM_i_valid & (regM_i_mem_ren | regM_i_mem_wen);
  assign w_misaligned = is_misaligned(regM_i_funct3[1:0], w_in_off);

  mem_load_align u_load_align (
    .i_rdata  (dmem.rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  always_comb begin
    w_next_state        = r_state;
    w_latch             = 1'b0;
    w_capture           = 1'b0;
    memory_o_stall      = 1'b0;
    memory_o_misaligned = 1'b0;
    dmem.req_valid      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misaligned) begin
            memory_o_misaligned = 1'b1;
          end else begin
            memory_o_stall = 1'b1;
            w_latch        = 1'b1;
            w_next_state   = REQ;
          end
        end
      end
      REQ: begin
        dmem.req_valid = 1'b1;
        memory_o_stall = 1'b1;
        if (dmem.req_ready) w_next_state = WAIT;
      end
      WAIT: begin
        memory_o_stall = 1'b1;
        if (dmem.resp_valid) begin
          w_capture    = ~r_req_wen;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Store data and strobes are lane-formatted at latch time, so the request
  // fields are plain registers and cannot move while req_valid is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_funct3    <= '0;
      r_off       <= '0;
      r_req_addr  <= '0;
      r_req_wen   <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_memdata   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_funct3    <= regM_i_funct3;
        r_off       <= w_in_off;
        r_req_addr  <= {regM_i_alu_result[63:3], 3'b000};
        r_req_wen   <= regM_i_mem_wen;
        r_req_wdata <= regM_i_mem_wen ? (regM_i_rs2_data << {w_in_off, 3'b000}) : '0;
        r_req_wstrb <= regM_i_mem_wen ? byte_mask(regM_i_funct3[1:0], w_in_off) : '0;
      end
      if (w_capture) r_memdata <= w_load_data;
    end
  end

  assign dmem.addr        = r_req_addr;
  assign dmem.wen         = r_req_wen;
  assign dmem.wdata       = r_req_wdata;
  assign dmem.wstrb       = r_req_wstrb;
  assign memory_o_memdata = r_memdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a request/result scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regM_valid = 1'b0;
  logic        regM_ren = 1'b0;
  logic        regM_wen = 1'b0;
  logic [2:0]  regM_f3 = '0;
  logic [63:0] regM_addr = '0;
  logic [63:0] regM_rs2 = '0;
  logic [63:0] memdata;
  logic        stall;
  logic        mis;

  always #5 clk = ~clk;

  mem_access_unit_if dmem ();

  mem_access_unit u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .regM_i_valid        (regM_valid),
    .regM_i_mem_ren      (regM_ren),
    .regM_i_mem_wen      (regM_wen),
    .regM_i_funct3       (regM_f3),
    .regM_i_alu_result   (regM_addr),
    .regM_i_rs2_data     (regM_rs2),
    .dmem                (dmem),
    .memory_o_memdata    (memdata),
    .memory_o_stall      (stall),
    .memory_o_misaligned (mis)
  );

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [63:0] mem_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op at the current negedge and plays the bus slave:
  // req_ready low for the first ready_low cycles, response resp_lat cycles
  // after acceptance. Returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic ren, input logic wen,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] rs2, input logic [63:0] rdata,
                       input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                       input logic [7:0] exp_wstrb, input logic [63:0] exp_mem,
                       input int ready_low, input int resp_lat, input int exp_stall);
    req_t r;
    int   cyc     = 0;
    int   acc     = -1;
    int   first_q = -1;
    int   stall_n = 0;
    bit   done    = 0;
    r.addr = exp_addr; r.wen = wen; r.wdata = exp_wdata; r.wstrb = exp_wstrb;
    req_q.push_back(r);
    mem_q.push_back(exp_mem);
    regM_valid = 1'b1; regM_ren = ren; regM_wen = wen;
    regM_f3 = f3; regM_addr = addr; regM_rs2 = rs2;
    while (!done && cyc < 60) begin
      dmem.req_ready  = (cyc >= ready_low);
      dmem.resp_valid = (acc >= 0) && (cyc == acc + resp_lat);
      dmem.rdata      = dmem.resp_valid ? rdata : {$urandom, $urandom};
      #1;
      if (stall) stall_n++;
      if (dmem.req_valid) begin
        if (first_q < 0) first_q = cyc;
        check({tag, "_reqq"}, req_q.size(), 1);
        if (req_q.size() > 0) begin
          check({tag, "_addr"},  dmem.addr,  req_q[0].addr);
          check({tag, "_wen"},   dmem.wen,   req_q[0].wen);
          check({tag, "_wdata"}, dmem.wdata, req_q[0].wdata);
          check({tag, "_wstrb"}, dmem.wstrb, req_q[0].wstrb);
          if (dmem.req_ready && acc < 0) begin
            acc = cyc;
            void'(req_q.pop_front());
          end
        end
      end
      if (cyc > 0 && !stall) begin
        done = 1;
        check({tag, "_memdata"}, memdata, mem_q.pop_front());
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_stall_cycles"}, stall_n, exp_stall);
    check({tag, "_first_req_cycle"}, first_q, 1);
    @(negedge clk);
    regM_valid = 1'b0; regM_ren = 1'b0; regM_wen = 1'b0;
    dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0;
    if (!done) $fatal(1, "FAIL %s timeout", tag);
  endtask

  initial begin
    dmem.req_ready  = 1'b0;
    dmem.resp_valid = 1'b0;
    dmem.rdata      = '0;

    repeat (3) @(negedge clk);
    check("rst_req_valid", dmem.req_valid, 0);
    check("rst_wen",       dmem.wen,       0);
    check("rst_addr",      dmem.addr,      0);
    check("rst_wdata",     dmem.wdata,     0);
    check("rst_wstrb",     dmem.wstrb,     0);
    check("rst_memdata",   memdata,        0);
    check("rst_stall",     stall,          0);
    check("rst_mis",       mis,            0);
    rst = 1'b1;
    @(negedge clk);
    #1 check("idle_stall", stall, 0);
    @(negedge clk);

    do_op("lb", 1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
          64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 3);
    do_op("sh", 0, 1, 3'b001, 64'h2006, 64'hABCD, 64'hDEAD_BEEF_0BAD_F00D,
          64'h2000, 64'hABCD_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 3);

    regM_valid = 1'b1; regM_ren = 1'b1; regM_wen = 1'b0;
    regM_f3 = 3'b010; regM_addr = 64'h3002; dmem.req_ready = 1'b1;
    #1;
    check("mis_lw_flag",  mis,            1);
    check("mis_lw_stall", stall,          0);
    check("mis_lw_req",   dmem.req_valid, 0);
    @(negedge clk);
    regM_ren = 1'b0; regM_wen = 1'b1; regM_f3 = 3'b001; regM_addr = 64'h2001;
    #1;
    check("mis_sh_flag", mis,            1);
    check("mis_sh_req",  dmem.req_valid, 0);
    @(negedge clk);
    regM_ren = 1'b1; regM_wen = 1'b0; regM_f3 = 3'b011; regM_addr = 64'h4004;
    #1;
    check("mis_ld_flag", mis, 1);
    @(negedge clk);
    regM_valid = 1'b0; regM_ren = 1'b0; dmem.resp_valid = 1'b1;
    dmem.rdata = 64'h5555_AAAA_5555_AAAA;
    #1;
    check("mis_clear",   mis,            0);
    check("mis_no_req",  dmem.req_valid, 0);
    @(negedge clk);
    dmem.resp_valid = 1'b0; dmem.req_ready = 1'b0;
    #1;
    check("idle_resp_ignored", memdata,        64'hFFFF_FFFF_FFFF_FF80);
    check("idle_no_req",       dmem.req_valid, 0);
    @(negedge clk);

    do_op("bp_ld", 1, 0, 3'b011, 64'h4000, 64'h0, 64'h1122_3344_5566_7788,
          64'h4000, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 4, 2, 7);

    regM_valid = 1'b1; regM_ren = 1'b1; regM_f3 = 3'b011; regM_addr = 64'h4010;
    dmem.req_ready = 1'b1;
    @(negedge clk);
    #1 check("rm_req", dmem.req_valid, 1);
    @(negedge clk);
    rst = 1'b0; regM_valid = 1'b0; regM_ren = 1'b0; dmem.req_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rm_req_valid", dmem.req_valid, 0);
    check("rm_memdata",   memdata,        0);
    check("rm_stall",     stall,          0);
    rst = 1'b1;
    @(negedge clk);
    dmem.resp_valid = 1'b1; dmem.rdata = 64'hCAFE_F00D_CAFE_F00D;
    #1 check("rm_late_req", dmem.req_valid, 0);
    @(negedge clk);
    dmem.resp_valid = 1'b0;
    #1;
    check("rm_late_memdata", memdata,        0);
    check("rm_late_stall",   stall,          0);
    check("rm_late_req2",    dmem.req_valid, 0);
    @(negedge clk);

    do_op("b2b_lwu", 1, 0, 3'b110, 64'h5004, 64'h0, 64'h8000_0001_1234_5678,
          64'h5000, 64'h0, 8'h00, 64'h0000_0000_8000_0001, 0, 1, 3);
    do_op("b2b_sb", 0, 1, 3'b000, 64'h5001, 64'h55, 64'h0,
          64'h5000, 64'h5500, 8'h02, 64'h0000_0000_8000_0001, 0, 1, 3);
    do_op("lw", 1, 0, 3'b010, 64'h6004, 64'h0, 64'hF234_5678_0000_0000,
          64'h6000, 64'h0, 8'h00, 64'hFFFF_FFFF_F234_5678, 0, 1, 3);
    do_op("lhu", 1, 0, 3'b101, 64'h6002, 64'h0, 64'h0000_0000_9ABC_0000,
          64'h6000, 64'h0, 8'h00, 64'h0000_0000_0000_9ABC, 0, 1, 3);
    do_op("f3_111", 1, 0, 3'b111, 64'h6008, 64'h0, 64'h0123_4567_89AB_CDEF,
          64'h6008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 1, 3);
    do_op("sw", 0, 1, 3'b010, 64'h7004, 64'h0000_0000_CAFE_BABE, 64'h0,
          64'h7000, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0123_4567_89AB_CDEF, 0, 1, 3);
    do_op("sd", 0, 1, 3'b011, 64'h7000, 64'hFEDC_BA98_7654_3210, 64'h0,
          64'h7000, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 1, 3);
    do_op("lbu", 1, 0, 3'b100, 64'h7007, 64'h0, 64'h9900_0000_0000_0000,
          64'h7000, 64'h0, 8'h00, 64'h0000_0000_0000_0099, 2, 3, 6);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
